motion_search: RTL and testbench

- Search controller that sits directly upstream of the macroblock comparator.
- For one current macroblock it sweeps candidate motion vectors (dx, dy) over a clipped search window and launches one comparator run per candidate.
- It passes the best SAD found so far as the comparator's early-termination bound, and records the winning vector and SAD.
- Downstream consumers (residual encoder, vector coder) read best_dx/best_dy/best_sad after done.

---
 rtl/motion_pkg.sv | 26 ++
 rtl/motion_search_if.sv | 44 ++++
 rtl/mv_window_iter.sv | 93 +++++++++
 rtl/motion_search.sv | 156 +++++++++++++++
 tb/tb_motion_search.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// Shared types and constants for the motion search controller.
//   - ACCW_DEF / RANGE_DEF / EXIT_THRESH_DEF : default parameter values
//   - VW      : width of a signed motion-vector component
//   - mv_t    : signed motion-vector component
//   - ms_state_e : search controller state encoding
//   - SAD_MAX : all-ones SAD at the default accumulator width
package motion_pkg;

  localparam int unsigned ACCW_DEF        = 18;
  localparam int unsigned RANGE_DEF       = 7;
  localparam int unsigned EXIT_THRESH_DEF = 512;
  localparam int unsigned VW              = 5;

  typedef logic signed [VW-1:0] mv_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } ms_state_e;

  localparam logic [ACCW_DEF-1:0] SAD_MAX = '1;

endpackage

// File: rtl/motion_search_if.sv
// Bus bundle between the motion search controller, its requester, the
// previous-frame fetcher and the macroblock comparator.
//   slave  : the controller's view (motion_search)
//   master : the environment's view (requester + comparator)
interface motion_search_if
  import motion_pkg::*;
#(
  parameter int unsigned ACCW = ACCW_DEF
);

  logic            start;
  logic            busy;
  logic            done;
  mv_t             win_min_dx;
  mv_t             win_max_dx;
  mv_t             win_min_dy;
  mv_t             win_max_dy;
  mv_t             cand_dx;
  mv_t             cand_dy;
  logic            cmp_en;
  logic            cmp_rdy;
  logic            cmp_valid;
  logic [ACCW-1:0] cmp_accum;
  logic [ACCW-1:0] cmp_oldaccum;
  mv_t             best_dx;
  mv_t             best_dy;
  logic [ACCW-1:0] best_sad;
  logic            found;

  modport slave (
    input  start, win_min_dx, win_max_dx, win_min_dy, win_max_dy,
           cmp_rdy, cmp_valid, cmp_accum,
    output busy, done, cand_dx, cand_dy, cmp_en, cmp_oldaccum,
           best_dx, best_dy, best_sad, found
  );

  modport master (
    output start, win_min_dx, win_max_dx, win_min_dy, win_max_dy,
           cmp_rdy, cmp_valid, cmp_accum,
    input  busy, done, cand_dx, cand_dy, cmp_en, cmp_oldaccum,
           best_dx, best_dy, best_sad, found
  );

endinterface

// File: rtl/mv_window_iter.sv
// Search-window clipper and raster candidate counter (dx fastest).
//   clk, reset      : clock, async active-high reset
//   load_i          : latch clipped window, set candidate to (lo_dx, lo_dy)
//   adv_i           : step to the next raster candidate
//   win_*_i         : requested signed window limits
//   cand_dx_o/dy_o  : current candidate (registered)
//   empty_c         : clipped request window is empty (from live inputs)
//   last_c          : current candidate is the last one of the latched window
module mv_window_iter
  import motion_pkg::*;
#(
  parameter int unsigned RANGE = RANGE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic adv_i,
  input  mv_t  win_min_dx_i,
  input  mv_t  win_max_dx_i,
  input  mv_t  win_min_dy_i,
  input  mv_t  win_max_dy_i,
  output mv_t  cand_dx_o,
  output mv_t  cand_dy_o,
  output logic empty_c,
  output logic last_c
);

  localparam mv_t NEG_R = VW'(-int'(RANGE));
  localparam mv_t POS_R = VW'(RANGE);

  mv_t lo_dx_c, hi_dx_c, lo_dy_c, hi_dy_c;
  mv_t lo_dx_q, hi_dx_q, lo_dy_q, hi_dy_q;
  mv_t lo_dx_d, hi_dx_d, lo_dy_d, hi_dy_d;
  mv_t dx_q, dy_q, dx_d, dy_d;

  // Clip the request against +/-RANGE (signed compares)
  always_comb begin
    lo_dx_c = (win_min_dx_i > NEG_R) ? win_min_dx_i : NEG_R;
    hi_dx_c = (win_max_dx_i < POS_R) ? win_max_dx_i : POS_R;
    lo_dy_c = (win_min_dy_i > NEG_R) ? win_min_dy_i : NEG_R;
    hi_dy_c = (win_max_dy_i < POS_R) ? win_max_dy_i : POS_R;
  end

  assign empty_c = (lo_dx_c > hi_dx_c) || (lo_dy_c > hi_dy_c);
  assign last_c  = (dx_q == hi_dx_q) && (dy_q == hi_dy_q);

  // Window latch and raster advance
  always_comb begin
    lo_dx_d = lo_dx_q;
    hi_dx_d = hi_dx_q;
    lo_dy_d = lo_dy_q;
    hi_dy_d = hi_dy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (load_i) begin
      lo_dx_d = lo_dx_c;
      hi_dx_d = hi_dx_c;
      lo_dy_d = lo_dy_c;
      hi_dy_d = hi_dy_c;
      dx_d    = lo_dx_c;
      dy_d    = lo_dy_c;
    end else if (adv_i) begin
      if (dx_q == hi_dx_q) begin
        dx_d = lo_dx_q;
        dy_d = dy_q + VW'(1);
      end else begin
        dx_d = dx_q + VW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_dx_q <= '0;
      hi_dx_q <= '0;
      lo_dy_q <= '0;
      hi_dy_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      lo_dx_q <= lo_dx_d;
      hi_dx_q <= hi_dx_d;
      lo_dy_q <= lo_dy_d;
      hi_dy_q <= hi_dy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  assign cand_dx_o = dx_q;
  assign cand_dy_o = dy_q;

endmodule

// File: rtl/motion_search.sv
// Motion search controller: sweeps candidate vectors over a clipped window,
// launches one comparator run per candidate with the best SAD so far as the
// early-termination bound, and records the winning vector and SAD.
//   clk, reset : clock, async active-high reset
//   bus        : motion_search_if.slave (start/busy/done, window limits,
//                candidate vector, comparator handshake, best result)
// Optional feature: define MS_EARLY_EXIT_EN to stop the sweep as soon as a
// new best SAD is <= EXIT_THRESH.
module motion_search
  import motion_pkg::*;
#(
  parameter int unsigned RANGE       = RANGE_DEF,
  parameter int unsigned ACCW        = ACCW_DEF,
  parameter int unsigned EXIT_THRESH = EXIT_THRESH_DEF
) (
  input logic             clk,
  input logic             reset,
  motion_search_if.slave  bus
);

`ifdef MS_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  ms_state_e       state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cmp_en_q, cmp_en_d;
  mv_t             best_dx_q, best_dx_d;
  mv_t             best_dy_q, best_dy_d;
  logic [ACCW-1:0] best_sad_q, best_sad_d;
  logic            found_q, found_d;
  logic            hit_q, hit_d;

  logic load_c, adv_c, empty_c, last_c, update_c;
  mv_t  cand_dx, cand_dy;

  mv_window_iter #(.RANGE(RANGE)) u_iter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load_c),
    .adv_i        (adv_c),
    .win_min_dx_i (bus.win_min_dx),
    .win_max_dx_i (bus.win_max_dx),
    .win_min_dy_i (bus.win_min_dy),
    .win_max_dy_i (bus.win_max_dy),
    .cand_dx_o    (cand_dx),
    .cand_dy_o    (cand_dy),
    .empty_c      (empty_c),
    .last_c       (last_c)
  );

  // Strict less-than keeps the earlier candidate on ties
  assign update_c = bus.cmp_valid && (!found_q || (bus.cmp_accum < best_sad_q));

  // Next-state, best tracking and registered-output precompute
  always_comb begin
    state_d    = state_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    cmp_en_d   = 1'b0;
    load_c     = 1'b0;
    adv_c      = 1'b0;
    best_dx_d  = best_dx_q;
    best_dy_d  = best_dy_q;
    best_sad_d = best_sad_q;
    found_d    = found_q;
    hit_d      = hit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load_c     = 1'b1;
          best_sad_d = '1;
          found_d    = 1'b0;
          hit_d      = 1'b0;
          state_d    = empty_c ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.cmp_rdy) begin
          cmp_en_d = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // rdy is still high during the launch cycle itself; ignore it then
        if (bus.cmp_rdy && !cmp_en_q) begin
          hit_d = update_c && EARLY_EXIT && (bus.cmp_accum <= ACCW'(EXIT_THRESH));
          if (update_c) begin
            best_dx_d  = cand_dx;
            best_dy_d  = cand_dy;
            best_sad_d = bus.cmp_accum;
            found_d    = 1'b1;
          end
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_c || hit_q) begin
          state_d = ST_FINISH;
        end else begin
          adv_c   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_NEXT);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmp_en_q   <= 1'b0;
      best_dx_q  <= '0;
      best_dy_q  <= '0;
      best_sad_q <= '1;
      found_q    <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmp_en_q   <= cmp_en_d;
      best_dx_q  <= best_dx_d;
      best_dy_q  <= best_dy_d;
      best_sad_q <= best_sad_d;
      found_q    <= found_d;
      hit_q      <= hit_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cmp_en       = cmp_en_q;
  assign bus.cand_dx      = cand_dx;
  assign bus.cand_dy      = cand_dy;
  assign bus.cmp_oldaccum = best_sad_q;
  assign bus.best_dx      = best_dx_q;
  assign bus.best_dy      = best_dy_q;
  assign bus.best_sad     = best_sad_q;
  assign bus.found        = found_q;

endmodule

// File: tb/tb_motion_search.sv
// Self-checking bench for motion_search with RANGE=1 and a behavioural
// comparator (rdy/valid handshake, per-candidate SAD table, early
// termination when SAD exceeds the supplied bound).
module tb_motion_search;
  import motion_pkg::*;

  localparam int RANGE       = 1;
  localparam int ACCW        = 18;
  localparam int EXIT_THRESH = 512;
  localparam int RUN_LEN     = 3;
`ifdef MS_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef struct {
    int dx;
    int dy;
  } mv_rec_t;

  typedef struct {
    int     dx;
    int     dy;
    longint sad;
    int     found;
    int     n;
  } result_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  motion_search_if #(.ACCW(ACCW)) ms();

  motion_search #(
    .RANGE       (RANGE),
    .ACCW        (ACCW),
    .EXIT_THRESH (EXIT_THRESH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ms.slave)
  );

  mv_rec_t launch_q[$];
  result_t res_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      launch_cnt = 0;
  int      search_base;
  int      sad_tbl [3][3];   // [dy+1][dx+1]
  logic    force_low;
  logic    prev_en = 1'b0;
  mv_rec_t cur;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Comparator model
  logic rdy_q;
  int   run_cnt;
  logic [ACCW-1:0] run_sad;
  assign ms.cmp_rdy = rdy_q && !force_low;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q        <= 1'b1;
      run_cnt      <= 0;
      run_sad      <= '0;
      ms.cmp_valid <= 1'b0;
      ms.cmp_accum <= '0;
    end else if (run_cnt != 0) begin
      run_cnt <= run_cnt - 1;
      if (run_cnt == 1) begin
        rdy_q        <= 1'b1;
        ms.cmp_valid <= (run_sad <= ms.cmp_oldaccum);
        ms.cmp_accum <= run_sad;
      end
    end else if (ms.cmp_en && ms.cmp_rdy) begin
      rdy_q        <= 1'b0;
      run_cnt      <= RUN_LEN;
      run_sad      <= ACCW'(sad_tbl[int'(ms.cand_dy) + RANGE][int'(ms.cand_dx) + RANGE]);
      ms.cmp_valid <= 1'b0;
    end
  end

  // Launch monitor: order, pulse width and candidate stability
  always @(negedge clk) begin
    if (!reset) begin
      if (ms.cmp_en) begin
        launch_cnt++;
        check("en_pulse_width", prev_en, 0);
        check("launch_expected", launch_q.size() > 0, 1);
        if (launch_q.size() > 0) begin
          cur = launch_q.pop_front();
          check("launch_dx", ms.cand_dx, cur.dx);
          check("launch_dy", ms.cand_dy, cur.dy);
        end
      end else if (run_cnt != 0) begin
        check("stable_dx", ms.cand_dx, cur.dx);
        check("stable_dy", ms.cand_dy, cur.dy);
      end
      prev_en = ms.cmp_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  // Reference sweep: raster order, first strict minimum wins
  task automatic expect_search(input int mnx, input int mxx, input int mny, input int mxy);
    int lx, hx, ly, hy;
    bit stop;
    result_t r;
    mv_rec_t m;
    lx = (mnx > -RANGE) ? mnx : -RANGE;
    hx = (mxx <  RANGE) ? mxx :  RANGE;
    ly = (mny > -RANGE) ? mny : -RANGE;
    hy = (mxy <  RANGE) ? mxy :  RANGE;
    r.found = 0; r.sad = (longint'(1) << ACCW) - 1; r.dx = 0; r.dy = 0; r.n = 0;
    stop = 1'b0;
    if (lx <= hx && ly <= hy) begin
      for (int y = ly; y <= hy && !stop; y++) begin
        for (int x = lx; x <= hx && !stop; x++) begin
          m.dx = x; m.dy = y;
          launch_q.push_back(m);
          r.n++;
          if (r.found == 0 || longint'(sad_tbl[y + RANGE][x + RANGE]) < r.sad) begin
            r.found = 1;
            r.sad   = sad_tbl[y + RANGE][x + RANGE];
            r.dx    = x;
            r.dy    = y;
            if (EARLY_EXIT && r.sad <= EXIT_THRESH) stop = 1'b1;
          end
        end
      end
    end
    res_q.push_back(r);
  endtask

  task automatic begin_search(input int mnx, input int mxx, input int mny, input int mxy);
    expect_search(mnx, mxx, mny, mxy);
    search_base   = launch_cnt;
    ms.win_min_dx = VW'(mnx);
    ms.win_max_dx = VW'(mxx);
    ms.win_min_dy = VW'(mny);
    ms.win_max_dy = VW'(mxy);
    ms.start      = 1'b1;
    @(negedge clk);
    ms.start      = 1'b0;
  endtask

  task automatic finish_search(input string name, input bit poke_start, output int cycles);
    result_t r;
    cycles = 1;
    while (!ms.done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_done_seen"}, ms.done, 1);
    check({name, "_busy_at_done"}, ms.busy, 0);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      check({name, "_found"}, ms.found, r.found);
      check({name, "_best_sad"}, ms.best_sad, r.sad);
      check({name, "_oldaccum"}, ms.cmp_oldaccum, r.sad);
      check({name, "_launches"}, launch_cnt - search_base, r.n);
      if (r.found != 0) begin
        check({name, "_best_dx"}, ms.best_dx, r.dx);
        check({name, "_best_dy"}, ms.best_dy, r.dy);
      end
    end
    if (poke_start) ms.start = 1'b1;
    @(negedge clk);
    ms.start = 1'b0;
    check({name, "_done_pulse"}, ms.done, 0);
    check({name, "_idle_busy"}, ms.busy, 0);
    if (poke_start) begin
      @(negedge clk);
      check({name, "_start_at_done_ignored"}, ms.busy, 0);
      check({name, "_no_relaunch"}, launch_cnt - search_base, r.n);
    end
  endtask

  initial begin
    int cyc;
    int n;
    reset     = 1'b1;
    force_low = 1'b0;
    ms.start  = 1'b0;
    ms.win_min_dx = '0; ms.win_max_dx = '0;
    ms.win_min_dy = '0; ms.win_max_dy = '0;
    sad_tbl = '{'{700, 650, 40}, '{300, 200, 150}, '{900, 800, 100}};
    repeat (2) @(negedge clk);
    check("rst_busy", ms.busy, 0);
    check("rst_done", ms.done, 0);
    check("rst_cmp_en", ms.cmp_en, 0);
    check("rst_found", ms.found, 0);
    check("rst_best_sad", ms.best_sad, SAD_MAX);
    check("rst_oldaccum", ms.cmp_oldaccum, SAD_MAX);
    check("rst_best_dx", ms.best_dx, 0);
    reset = 1'b0;
    @(negedge clk);

    // Distinct SADs, minimum 40 at (1,-1); start re-asserted with done
    begin_search(-1, 1, -1, 1);
    check("sweep_busy", ms.busy, 1);
    finish_search("distinct", 1'b1, cyc);

    // Ties at (-1,-1) and (0,0)
    sad_tbl = '{'{30, 90, 80}, '{70, 30, 60}, '{50, 40, 45}};
    begin_search(-1, 1, -1, 1);
    finish_search("ties", 1'b0, cyc);

    // Clipped partial window: dx -1..0, dy 0..1
    sad_tbl = '{'{700, 650, 40}, '{300, 200, 150}, '{900, 800, 100}};
    begin_search(-5, 0, 0, 3);
    finish_search("clip", 1'b0, cyc);

    // Empty window after clipping
    begin_search(2, 5, -1, 1);
    finish_search("empty", 1'b0, cyc);
    check("empty_latency_ok", cyc <= 2, 1);

    // Reset during the 4th candidate's comparator run
    begin_search(-1, 1, -1, 1);
    n = 0;
    while (launch_cnt - search_base < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_4th", launch_cnt - search_base >= 4, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", ms.busy, 0);
    check("rst_mid_cmp_en", ms.cmp_en, 0);
    check("rst_mid_best_sad", ms.best_sad, SAD_MAX);
    check("rst_mid_found", ms.found, 0);
    launch_q.delete();
    res_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    begin_search(-1, 1, -1, 1);
    finish_search("after_reset", 1'b0, cyc);

    // Comparator not ready for 10 cycles; start while busy is ignored
    sad_tbl = '{'{30, 90, 80}, '{70, 30, 60}, '{50, 40, 45}};
    force_low = 1'b1;
    begin_search(-1, 1, -1, 1);
    for (int i = 0; i < 10; i++) begin
      check("hold_cmp_en", ms.cmp_en, 0);
      check("hold_busy", ms.busy, 1);
      check("hold_cand_dx", ms.cand_dx, -1);
      check("hold_cand_dy", ms.cand_dy, -1);
      ms.start = (i == 4);
      @(negedge clk);
    end
    ms.start  = 1'b0;
    force_low = 1'b0;
    finish_search("rdy_low", 1'b0, cyc);

    // First candidate SAD 100 (single launch when early exit is built in)
    sad_tbl = '{'{100, 300, 400}, '{500, 20, 600}, '{700, 800, 900}};
    begin_search(-1, 1, -1, 1);
    finish_search("first100", 1'b0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
